// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: FSM states and shift op codes.
// The shifter ALU and the sequencer FSM both take these from here.
package shift_sequencer_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL     = 2'b00;
  localparam logic [1:0] OP_SRL     = 2'b01;
  localparam logic [1:0] OP_SRA     = 2'b10;
  localparam logic [1:0] OP_SRL_RSV = 2'b11;

endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// One stage of a logarithmic shifter: shifts by 2^i_stage when enabled.
// Op code 11 falls into the logical-right branch on purpose.
module shift_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_stage,
  input  logic [1:0]       i_op,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);
  import shift_sequencer_pkg::*;

  logic [4:0] w_amt;

  assign w_amt = 5'd1 << i_stage;

  // Select the shifted word for the requested op, or pass the input through.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        OP_SLL:  o_data = i_data << w_amt;
        OP_SRA:  o_data = $unsigned($signed(i_data) >>> w_amt);
        default: o_data = i_data >> w_amt;
      endcase
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one shift_stage reused for stages 4..0, fixed
// latency of five SHIFT cycles followed by a one-cycle DONE pulse.
module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  input  logic [4:0]       i_shamt,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_out,
  output logic             o_busy,
  output logic             o_done
);
  import shift_sequencer_pkg::*;

  state_t             r_state;
  logic [WIDTH-1:0]   r_out;
  logic [STAGE_W-1:0] r_cnt;
  logic [SHAMT_W-1:0] r_shamt;
  logic [1:0]         r_op;
  logic               r_busy;
  logic               r_done;

  logic               w_stage_en;
  logic [WIDTH-1:0]   w_stage_out;

  // The latched shamt bit for the current stage decides whether it shifts.
  assign w_stage_en = (r_state == ST_SHIFT) &&
                      (((r_shamt >> r_cnt) & 5'd1) != 5'd0);

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .i_data  (r_out),
    .i_stage (r_cnt),
    .i_op    (r_op),
    .i_en    (w_stage_en),
    .o_data  (w_stage_out)
  );

  // Sequencer FSM; busy and done are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_cnt   <= 3'd0;
      r_shamt <= 5'd0;
      r_op    <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_out   <= i_data;
            r_shamt <= i_shamt;
            r_op    <= i_op;
            r_cnt   <= 3'd4;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_out <= w_stage_out;
          if (r_cnt == 3'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a timeline model predicts acceptance,
// busy/done windows and results; a negedge monitor compares against the DUT.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic [31:0] out;
  logic        busy;
  logic        done;

  shift_sequencer #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_data  (data),
    .i_shamt (shamt),
    .i_op    (op),
    .o_out   (out),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          acc = -100;
  int          next_ok = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_out = 32'd0;
  logic [31:0] sb_q[$];

  // Whole-word reference shift, straight from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    if (o == 2'b00) return d << s;
    else if (o == 2'b10) return sd >>> s;
    else return d >> s;
  endfunction

  // Timeline model: decides at each edge whether a start is accepted.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      sb_q.delete();
      acc     = -100;
      next_ok = cyc + 1;
      exp_out = 32'd0;
      mon_en  = 1'b1;
    end else if (start && cyc >= next_ok) begin
      exp_out = ref_shift(data, shamt, op);
      sb_q.push_back(exp_out);
      acc     = cyc;
      next_ok = cyc + 6;
    end
  end

  // Monitor: checks busy/done windows, popped results and held output value.
  always @(negedge clk) begin
    if (mon_en) begin
      logic eb, ed;
      logic [31:0] e;
      eb = (cyc >= acc) && (cyc <= acc + 4);
      ed = (cyc == acc + 5);
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
      vectors++;
      if (done !== ed) begin
        miscompares++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, ed);
      end
      if (done === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL result cyc=%0d got=%h exp=<none queued>", cyc, out);
        end else begin
          e = sb_q.pop_front();
          if (out !== e) begin
            miscompares++;
            $display("FAIL result cyc=%0d got=%h exp=%h", cyc, out, e);
          end
        end
      end
      if (!eb) begin
        vectors++;
        if (out !== exp_out) begin
          miscompares++;
          $display("FAIL hold_out cyc=%0d got=%h exp=%h", cyc, out, exp_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    start = 1'b1; data = d; shamt = s; op = o;
    tick();
    start = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data = 32'd0; shamt = 5'd0; op = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    issue(32'h0000_0001, 5'd31, 2'b00);
    issue(32'h8000_0000, 5'd16, 2'b10);
    issue(32'h8000_0000, 5'd16, 2'b01);
    issue(32'hDEAD_BEEF, 5'd0,  2'b00);
    issue(32'hF000_0000, 5'd4,  2'b11);
    issue(32'h7FFF_FFFF, 5'd31, 2'b10);
    issue(32'hFFFF_FFFF, 5'd1,  2'b10);

    // Start re-asserted with new operands while the first op is shifting.
    start = 1'b1; data = 32'h0000_0010; shamt = 5'd4; op = 2'b00;
    tick();
    data = 32'hFFFF_FFFF; shamt = 5'd31; op = 2'b01;
    repeat (3) tick();
    start = 1'b0;
    repeat (6) tick();

    // Reset lands on the third SHIFT cycle, then a clean op follows.
    start = 1'b1; data = 32'h1234_5678; shamt = 5'd7; op = 2'b00;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    issue(32'hCAFE_F00D, 5'd13, 2'b10);

    // Start held high with fresh operands every cycle.
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      data = $urandom(); shamt = 5'($urandom_range(31, 0)); op = 2'($urandom_range(3, 0));
      tick();
    end
    start = 1'b0;
    repeat (8) tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(3, 0) != 0);
      data  = $urandom();
      shamt = 5'($urandom_range(31, 0));
      op    = 2'($urandom_range(3, 0));
      reset = ($urandom_range(63, 0) == 0);
      tick();
    end
    start = 1'b0; reset = 1'b0;
    repeat (10) tick();

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
